// File: rtl/down_counter_pkg.sv
// Shared types and defaults for the loadable down-counter with underflow reporting.
package down_counter_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } dc_state_t;

  localparam int DC_DEFAULT_WIDTH = 4;

endpackage : down_counter_pkg

// File: rtl/down_counter_underflow.sv
// Loadable WIDTH-bit down-counter with IDLE/RUN run control, sticky underflow flag and pulse.
// Define DOWN_COUNTER_AUTO_RELOAD_EN to reload the last loaded value on underflow instead of wrapping.
module down_counter_underflow
  import down_counter_pkg::*;
#(
  parameter int WIDTH = DC_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             stop,
  input  logic             enable,
  input  logic             clear,
  output logic [WIDTH-1:0] counter_out,
  output logic             running_out,
  output logic             underflow_out,
  output logic             underflow_pulse
);

  dc_state_t        state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             flag_q, flag_d;
  logic             pulse_q, pulse_d;
  logic             dec;
  logic             uf_event;
  logic [WIDTH-1:0] wrap_value;

`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload_q, reload_d;

  assign reload_d   = load ? load_value : reload_q;
  assign wrap_value = reload_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reload_q <= '0;
    end else begin
      reload_q <= reload_d;
    end
  end
`else
  assign wrap_value = '1;
`endif

  // Decrement qualifies on the current state, so a stop in the same cycle still counts.
  assign dec      = (state_q == ST_RUN) && enable && !load;
  assign uf_event = dec && (count_q == '0);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    if (stop) begin
      state_d = ST_IDLE;
    end else if (start) begin
      state_d = ST_RUN;
    end

    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (uf_event) begin
      count_d = wrap_value;
    end else if (dec) begin
      count_d = count_q - WIDTH'(1);
    end

    // Set beats clear so an underflow is never lost.
    flag_d = flag_q;
    if (load) begin
      flag_d = 1'b0;
    end else if (uf_event) begin
      flag_d = 1'b1;
    end else if (clear) begin
      flag_d = 1'b0;
    end

    pulse_d = uf_event;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      flag_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      flag_q  <= flag_d;
      pulse_q <= pulse_d;
    end
  end

  assign counter_out     = count_q;
  assign running_out     = (state_q == ST_RUN);
  assign underflow_out   = flag_q;
  assign underflow_pulse = pulse_q;

endmodule : down_counter_underflow

// File: tb/tb_down_counter_underflow.sv
// Directed self-checking bench for down_counter_underflow (WIDTH=4).
// Observed vector per check: {counter_out, running_out, underflow_out, underflow_pulse}.
module tb_down_counter_underflow;

  localparam int WIDTH = 4;

`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
  localparam logic [3:0] WRAP_FROM_LOAD2 = 4'd2;
  localparam logic [3:0] WRAP_FROM_LOAD0 = 4'd0;
`else
  localparam logic [3:0] WRAP_FROM_LOAD2 = 4'd15;
  localparam logic [3:0] WRAP_FROM_LOAD0 = 4'd15;
`endif

  logic             clk;
  logic             reset;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             start;
  logic             stop;
  logic             enable;
  logic             clear;
  logic [WIDTH-1:0] counter_out;
  logic             running_out;
  logic             underflow_out;
  logic             underflow_pulse;

  int n_compared;
  int n_mismatched;

  down_counter_underflow #(.WIDTH(WIDTH)) dut (
    .clk             (clk),
    .reset           (reset),
    .load            (load),
    .load_value      (load_value),
    .start           (start),
    .stop            (stop),
    .enable          (enable),
    .clear           (clear),
    .counter_out     (counter_out),
    .running_out     (running_out),
    .underflow_out   (underflow_out),
    .underflow_pulse (underflow_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ld, input logic [3:0] lv, input logic st, input logic sp,
                       input logic en, input logic cl);
    load       = ld;
    load_value = lv;
    start      = st;
    stop       = sp;
    enable     = en;
    clear      = cl;
  endtask

  task automatic test_reset();
    logic [6:0] exp;
    reset = 1'b0;
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #3;
    exp = 7'b0;
    n_compared++;
    if ({counter_out, running_out, underflow_out, underflow_pulse} !== exp) begin
      n_mismatched++;
      $display("FAIL reset_initial: got %b want %b", {counter_out, running_out, underflow_out, underflow_pulse}, exp);
    end
    reset = 1'b1;
    drive(1'b1, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    exp = {4'd5, 1'b1, 1'b0, 1'b0};
    n_compared++;
    if ({counter_out, running_out, underflow_out, underflow_pulse} !== exp) begin
      n_mismatched++;
      $display("FAIL load5_start: got %b want %b", {counter_out, running_out, underflow_out, underflow_pulse}, exp);
    end
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    exp = 7'b0;
    n_compared++;
    if ({counter_out, running_out, underflow_out, underflow_pulse} !== exp) begin
      n_mismatched++;
      $display("FAIL async_reset_midcount: got %b want %b", {counter_out, running_out, underflow_out, underflow_pulse}, exp);
    end
    reset = 1'b1;
    drive(1'b1, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    exp = {4'd3, 1'b1, 1'b0, 1'b0};
    n_compared++;
    if ({counter_out, running_out, underflow_out, underflow_pulse} !== exp) begin
      n_mismatched++;
      $display("FAIL load3_start_after_reset: got %b want %b", {counter_out, running_out, underflow_out, underflow_pulse}, exp);
    end
  endtask

  task automatic test_countdown_wrap();
    logic [6:0] exp_tbl [4];
    exp_tbl[0] = {4'd1, 1'b1, 1'b0, 1'b0};
    exp_tbl[1] = {4'd0, 1'b1, 1'b0, 1'b0};
    exp_tbl[2] = {WRAP_FROM_LOAD2, 1'b1, 1'b1, 1'b1};
    exp_tbl[3] = {WRAP_FROM_LOAD2, 1'b1, 1'b1, 1'b0};
    drive(1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 4'd0, 1'b0, 1'b0, (i < 3), 1'b0);
      step();
      n_compared++;
      if ({counter_out, running_out, underflow_out, underflow_pulse} !== exp_tbl[i]) begin
        n_mismatched++;
        $display("FAIL countdown_wrap[%0d]: got %b want %b", i, {counter_out, running_out, underflow_out, underflow_pulse}, exp_tbl[i]);
      end
    end
  endtask

  task automatic test_enable_gating();
    logic [3:0] exp_cnt [3];
    logic       en_tbl  [3];
    logic [6:0] exp;
    exp_cnt[0] = 4'd6; exp_cnt[1] = 4'd6; exp_cnt[2] = 4'd5;
    en_tbl[0]  = 1'b1; en_tbl[1]  = 1'b0; en_tbl[2]  = 1'b1;
    drive(1'b1, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 4'd0, 1'b0, 1'b0, en_tbl[i], 1'b0);
      step();
      n_compared++;
      if ({counter_out, running_out} !== {exp_cnt[i], 1'b1}) begin
        n_mismatched++;
        $display("FAIL enable_gating[%0d]: got %b want %b", i, {counter_out, running_out}, {exp_cnt[i], 1'b1});
      end
    end
    drive(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      step();
      exp = {4'd5, 1'b0, 1'b0, 1'b0};
      n_compared++;
      if ({counter_out, running_out, underflow_out, underflow_pulse} !== exp) begin
        n_mismatched++;
        $display("FAIL idle_enable_hold[%0d]: got %b want %b", i, {counter_out, running_out, underflow_out, underflow_pulse}, exp);
      end
    end
  endtask

  task automatic test_clear_vs_underflow();
    logic [6:0] exp;
    drive(1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    exp = {WRAP_FROM_LOAD0, 1'b1, 1'b1, 1'b1};
    n_compared++;
    if ({counter_out, running_out, underflow_out, underflow_pulse} !== exp) begin
      n_mismatched++;
      $display("FAIL clear_with_underflow: got %b want %b", {counter_out, running_out, underflow_out, underflow_pulse}, exp);
    end
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    exp = {WRAP_FROM_LOAD0, 1'b1, 1'b0, 1'b0};
    n_compared++;
    if ({counter_out, running_out, underflow_out, underflow_pulse} !== exp) begin
      n_mismatched++;
      $display("FAIL clear_alone: got %b want %b", {counter_out, running_out, underflow_out, underflow_pulse}, exp);
    end
  endtask

  task automatic test_start_stop_load();
    logic [6:0] exp;
    drive(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    n_compared++;
    if (running_out !== 1'b0) begin
      n_mismatched++;
      $display("FAIL start_stop_both_idle: running got %b want 0", running_out);
    end
    drive(1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    exp = {WRAP_FROM_LOAD0, 1'b1, 1'b1, 1'b1};
    n_compared++;
    if ({counter_out, running_out, underflow_out, underflow_pulse} !== exp) begin
      n_mismatched++;
      $display("FAIL underflow_before_load: got %b want %b", {counter_out, running_out, underflow_out, underflow_pulse}, exp);
    end
    drive(1'b1, 4'd9, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    exp = {4'd9, 1'b1, 1'b0, 1'b0};
    n_compared++;
    if ({counter_out, running_out, underflow_out, underflow_pulse} !== exp) begin
      n_mismatched++;
      $display("FAIL load_over_decrement: got %b want %b", {counter_out, running_out, underflow_out, underflow_pulse}, exp);
    end
    drive(1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    exp = {4'd8, 1'b0, 1'b0, 1'b0};
    n_compared++;
    if ({counter_out, running_out, underflow_out, underflow_pulse} !== exp) begin
      n_mismatched++;
      $display("FAIL stop_with_decrement: got %b want %b", {counter_out, running_out, underflow_out, underflow_pulse}, exp);
    end
  endtask

`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
  task automatic test_auto_reload();
    logic [6:0] exp_tbl [4];
    exp_tbl[0] = {4'd0, 1'b1, 1'b0, 1'b0};
    exp_tbl[1] = {4'd1, 1'b1, 1'b1, 1'b1};
    exp_tbl[2] = {4'd0, 1'b1, 1'b1, 1'b0};
    exp_tbl[3] = {4'd1, 1'b1, 1'b1, 1'b1};
    drive(1'b1, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      step();
      n_compared++;
      if ({counter_out, running_out, underflow_out, underflow_pulse} !== exp_tbl[i]) begin
        n_mismatched++;
        $display("FAIL auto_reload[%0d]: got %b want %b", i, {counter_out, running_out, underflow_out, underflow_pulse}, exp_tbl[i]);
      end
    end
  endtask
`endif

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    test_reset();
    test_countdown_wrap();
    test_enable_gating();
    test_clear_vs_underflow();
    test_start_stop_load();
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
    test_auto_reload();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule : tb_down_counter_underflow
